transpose_buffer_4x4: RTL

- Downstream stage of the 4-point row butterfly block in the HEVC 2-D DCT.
- Accepts one 4-sample row result per load, applies the first-stage rounding shift with saturation, and stores four rows.
- Replays the stored 4x4 block column by column to the column butterfly.
- Ping-pong double buffer, so back-to-back blocks stream with no gap.

---
 rtl/transpose_buffer_4x4_if.sv | 28 ++
 rtl/transpose_buffer_4x4.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/transpose_buffer_4x4_if.sv
// Row-in / column-out bus of the 4x4 transpose buffer.
// The producer of rows uses the master modport; the buffer itself uses slave.
interface transpose_buffer_4x4_if #(
  parameter int WIDTH_Y = 17,
  parameter int WIDTH_Q = 16
);
  logic                      load;
  logic signed [WIDTH_Y-1:0] d0;
  logic signed [WIDTH_Y-1:0] d1;
  logic signed [WIDTH_Y-1:0] d2;
  logic signed [WIDTH_Y-1:0] d3;
  logic signed [WIDTH_Q-1:0] q0;
  logic signed [WIDTH_Q-1:0] q1;
  logic signed [WIDTH_Q-1:0] q2;
  logic signed [WIDTH_Q-1:0] q3;
  logic                      out_valid;
  logic                      out_last;

  modport master (
    output load, d0, d1, d2, d3,
    input  q0, q1, q2, q3, out_valid, out_last
  );

  modport slave (
    input  load, d0, d1, d2, d3,
    output q0, q1, q2, q3, out_valid, out_last
  );
endinterface

// File: rtl/transpose_buffer_4x4.sv
// Ping-pong 4x4 transpose buffer between the row and column butterflies of
// the HEVC 4-point DCT. Rows are rounded/saturated on the way in, written to
// one bank, and replayed column by column from the other bank.
module transpose_buffer_4x4 #(
  parameter int WIDTH_Y = 17,
  parameter int WIDTH_Q = 16,
  parameter int SHIFT   = 1
) (
  input logic                  clk,
  input logic                  rst,
  transpose_buffer_4x4_if.slave bus
);

  typedef enum logic [2:0] {
    st_idle,
    st_col0,
    st_col1,
    st_col2,
    st_col3
  } state_t;

  // Rounding offset and saturation bounds, all at the widened WIDTH_Y+1 width.
  localparam logic signed [WIDTH_Y:0] RND   = (WIDTH_Y+1)'(2**(SHIFT-1));
  localparam logic signed [WIDTH_Y:0] Q_MAX = {{(WIDTH_Y+2-WIDTH_Q){1'b0}}, {(WIDTH_Q-1){1'b1}}};
  localparam logic signed [WIDTH_Y:0] Q_MIN = {{(WIDTH_Y+2-WIDTH_Q){1'b1}}, {(WIDTH_Q-1){1'b0}}};

  logic signed [WIDTH_Y-1:0] d_lane [4];
  logic signed [WIDTH_Q-1:0] r_lane [4];

  // bank_mem[bank][row][element]; contents are never reset.
  logic signed [WIDTH_Q-1:0] bank_mem [2][4][4];

  logic [1:0] wr_row_reg;
  logic       wr_bank_reg;
  logic       handoff;

  state_t     state_reg;
  state_t     state_next;
  logic       rd_bank_reg;
  logic       rd_bank_next;
  logic       emit;
  logic [1:0] emit_col;

  logic signed [WIDTH_Q-1:0] q_reg [4];
  logic                      out_valid_reg;
  logic                      out_last_reg;

  assign d_lane[0] = bus.d0;
  assign d_lane[1] = bus.d1;
  assign d_lane[2] = bus.d2;
  assign d_lane[3] = bus.d3;

  // Per-lane round-half-up, arithmetic shift, then clamp to the output range.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_round
      logic signed [WIDTH_Y:0] v_ext;
      logic signed [WIDTH_Y:0] v_sh;
      assign v_ext = {d_lane[gi][WIDTH_Y-1], d_lane[gi]} + RND;
      assign v_sh  = v_ext >>> SHIFT;
      assign r_lane[gi] = (v_sh > Q_MAX) ? Q_MAX[WIDTH_Q-1:0] :
                          (v_sh < Q_MIN) ? Q_MIN[WIDTH_Q-1:0] :
                                           v_sh[WIDTH_Q-1:0];
    end
  endgenerate

  // The fourth row of a bank completes the block and hands it to the reader.
  assign handoff = bus.load && (wr_row_reg == 2'd3);

  // Store the rounded row into the bank currently being filled.
  always_ff @(posedge clk) begin
    if (bus.load) begin
      for (int i = 0; i < 4; i++) begin
        bank_mem[wr_bank_reg][wr_row_reg][i] <= r_lane[i];
      end
    end
  end

  // Write pointer: row advances per load, bank flips after row 3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_row_reg  <= 2'd0;
      wr_bank_reg <= 1'b0;
    end else if (bus.load) begin
      wr_row_reg <= wr_row_reg + 2'd1;
      if (wr_row_reg == 2'd3) begin
        wr_bank_reg <= ~wr_bank_reg;
      end
    end
  end

  // Read engine state and the bank it is replaying.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= st_idle;
      rd_bank_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rd_bank_reg <= rd_bank_next;
    end
  end

  // Next-state: walk COL0..COL3; a handoff during COL3 chains straight into
  // the next block so back-to-back blocks leave no bubble.
  always_comb begin
    state_next   = state_reg;
    rd_bank_next = rd_bank_reg;
    emit         = 1'b0;
    emit_col     = 2'd0;
    case (state_reg)
      st_idle: begin
        if (handoff) begin
          state_next   = st_col0;
          rd_bank_next = wr_bank_reg;
        end
      end
      st_col0: begin
        emit       = 1'b1;
        emit_col   = 2'd0;
        state_next = st_col1;
      end
      st_col1: begin
        emit       = 1'b1;
        emit_col   = 2'd1;
        state_next = st_col2;
      end
      st_col2: begin
        emit       = 1'b1;
        emit_col   = 2'd2;
        state_next = st_col3;
      end
      st_col3: begin
        emit     = 1'b1;
        emit_col = 2'd3;
        if (handoff) begin
          state_next   = st_col0;
          rd_bank_next = wr_bank_reg;
        end else begin
          state_next = st_idle;
        end
      end
      default: begin
        state_next = st_idle;
      end
    endcase
  end

  // Registered column output; q holds its last column while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        q_reg[i] <= '0;
      end
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else begin
      out_valid_reg <= emit;
      out_last_reg  <= emit && (emit_col == 2'd3);
      if (emit) begin
        for (int i = 0; i < 4; i++) begin
          q_reg[i] <= bank_mem[rd_bank_reg][i][emit_col];
        end
      end
    end
  end

  assign bus.q0        = q_reg[0];
  assign bus.q1        = q_reg[1];
  assign bus.q2        = q_reg[2];
  assign bus.q3        = q_reg[3];
  assign bus.out_valid = out_valid_reg;
  assign bus.out_last  = out_last_reg;

endmodule
